// File: rtl/jtkcpu_irq_if.sv
// Interrupt-controller bus: raw CPU interrupt pins, CC mask bits and the
// handshake with the CPU sequencer.
// slave  = interrupt logic (jtkcpu_irq)
// master = CPU controller / pin drivers
interface jtkcpu_irq_if;
    logic        nmi_n;
    logic        firq_n;
    logic        irq_n;
    logic        cc_i;
    logic        cc_f;
    logic        insn_end;
    logic        int_ack;
    logic        int_done;
    logic        s_wr;
    logic        int_req;
    logic [15:0] vec_addr;
    logic        int_firq;
    logic        set_i;
    logic        set_f;

    modport slave (
        input  nmi_n, firq_n, irq_n, cc_i, cc_f,
        input  insn_end, int_ack, int_done, s_wr,
        output int_req, vec_addr, int_firq, set_i, set_f
    );

    modport master (
        output nmi_n, firq_n, irq_n, cc_i, cc_f,
        output insn_end, int_ack, int_done, s_wr,
        input  int_req, vec_addr, int_firq, set_i, set_f
    );
endinterface

// File: rtl/jtkcpu_irq.sv
// Interrupt arbiter for the KCPU core.
// Synchronises NMI/FIRQ/IRQ pins, latches NMI edges, picks the winner at an
// instruction boundary and hands the frozen vector to the controller.
// Priority: reset > NMI > FIRQ > IRQ.
// Optional build macro JTKCPU_NMI_ARM_EN: NMI edges are ignored until the
// first write to the S register after reset.
module jtkcpu_irq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    jtkcpu_irq_if.slave bus
);
    typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_REQ, ST_SVC} state_t;
    typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_FIRQ, SRC_IRQ} src_t;

    state_t     state, state_nxt;
    src_t       win, win_nxt;
    logic [2:0] sync_a, sync_b;      // {nmi, firq, irq}
    logic       nmi_last;
    logic       nmi_pend;
    logic       armed;
    logic       nmi_s, firq_s, irq_s;
    logic       nmi_fall, firq_pend, irq_pend;
    logic       clr_nmi, set_i, set_f;
    logic [15:0] vec;

    assign {nmi_s, firq_s, irq_s} = sync_b;

    // Two-stage pin synchronisers plus the previous NMI sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: synchronisers reset to the inactive level (1) so a released pin is not seen as an NMI edge
            sync_a   <= '1;
            sync_b   <= '1;
            nmi_last <= 1'b1;
        end else if (cen) begin
            sync_a   <= {bus.nmi_n, bus.firq_n, bus.irq_n};
            sync_b   <= sync_a;
            nmi_last <= nmi_s;
        end
    end

`ifdef JTKCPU_NMI_ARM_EN
    // NMI arming: the first S write after reset enables NMI edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                armed <= 1'b0;
        else if (cen && bus.s_wr) armed <= 1'b1;
    end
`else
    logic unused_s_wr;
    assign unused_s_wr = bus.s_wr;
    assign armed       = 1'b1;
`endif

    assign nmi_fall  = nmi_last & ~nmi_s & armed;
    assign firq_pend = ~firq_s & ~bus.cc_f;
    assign irq_pend  = ~irq_s  & ~bus.cc_i;

    // NMI pending latch; a fresh edge wins over the clear from an accepted NMI
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           nmi_pend <= 1'b0;
        else if (cen) begin
            if (nmi_fall)     nmi_pend <= 1'b1;
            else if (clr_nmi) nmi_pend <= 1'b0;
        end
    end

    // State and frozen-winner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RST;
            win   <= SRC_RST;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
        end
    end

    // Next-state, winner selection and mask-set pulses
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path infers a latch
        state_nxt = state;
        win_nxt   = win;
        set_i     = 1'b0;
        set_f     = 1'b0;
        clr_nmi   = 1'b0;
        case (state)
            ST_RST: begin
                if (cen && bus.int_ack && !rst) begin
                    set_i     = 1'b1;
                    set_f     = 1'b1;
                    state_nxt = ST_SVC;
                end
            end
            ST_IDLE: begin
                if (cen && bus.insn_end) begin
                    if (nmi_pend) begin
                        win_nxt   = SRC_NMI;
                        state_nxt = ST_REQ;
                    end else if (firq_pend) begin
                        win_nxt   = SRC_FIRQ;
                        state_nxt = ST_REQ;
                    end else if (irq_pend) begin
                        win_nxt   = SRC_IRQ;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (cen && bus.int_ack) begin
                    set_i     = 1'b1;
                    set_f     = (win != SRC_IRQ);
                    clr_nmi   = (win == SRC_NMI);
                    state_nxt = ST_SVC;
                end
            end
            ST_SVC: begin
                if (cen && bus.int_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // Vector decode from the frozen winner
    always_comb begin
        case (win)
            SRC_NMI:  vec = 16'hFFFC;
            SRC_FIRQ: vec = 16'hFFF6;
            SRC_IRQ:  vec = 16'hFFF8;
            default:  vec = 16'hFFFE;
        endcase
    end

    assign bus.int_req  = (state == ST_RST) || (state == ST_REQ);
    assign bus.vec_addr = vec;
    assign bus.int_firq = (win == SRC_FIRQ) && ((state == ST_REQ) || (state == ST_SVC));
    assign bus.set_i    = set_i;
    assign bus.set_f    = set_f;
endmodule

// File: tb/tb_jtkcpu_irq.sv
// Self-checking bench for jtkcpu_irq: directed scenarios plus a randomized
// loop checked against a priority model of the interrupt rules.
module tb_jtkcpu_irq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b1;

    jtkcpu_irq_if bus ();

    jtkcpu_irq dut (
        .rst (rst),
        .clk (clk),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit m_nmi  = 1'b0;     // model: an NMI edge is waiting for service

    localparam logic [15:0] V_RST  = 16'hFFFE;
    localparam logic [15:0] V_NMI  = 16'hFFFC;
    localparam logic [15:0] V_FIRQ = 16'hFFF6;
    localparam logic [15:0] V_IRQ  = 16'hFFF8;
    localparam logic [15:0] V_NONE = 16'h0000;

    // Reference priority rule: returns the vector that should be requested, or V_NONE
    function automatic logic [15:0] model_vec(bit nmi, logic firq_n, logic irq_n, logic cc_f, logic cc_i);
        if (nmi)                   return V_NMI;
        if (!firq_n && !cc_f)      return V_FIRQ;
        if (!irq_n && !cc_i)       return V_IRQ;
        return V_NONE;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        repeat (3) tick;
    endtask

    task automatic idle_pins;
        bus.nmi_n = 1'b1; bus.firq_n = 1'b1; bus.irq_n = 1'b1;
        bus.cc_i = 1'b0;  bus.cc_f = 1'b0;
        bus.insn_end = 1'b0; bus.int_ack = 1'b0; bus.int_done = 1'b0; bus.s_wr = 1'b0;
    endtask

    task automatic pulse_s_wr;
        bus.s_wr = 1'b1; tick; bus.s_wr = 1'b0;
    endtask

    task automatic nmi_edge;
        bus.nmi_n = 1'b0; settle; bus.nmi_n = 1'b1; settle;
    endtask

    // One insn_end pulse, then wait (bounded) for int_req
    task automatic request(output bit got, output logic [15:0] vec, output logic firq);
        got = 1'b0; vec = V_NONE; firq = 1'b0;
        bus.insn_end = 1'b1; tick; bus.insn_end = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (bus.int_req) begin
                got = 1'b1; vec = bus.vec_addr; firq = bus.int_firq;
            end else tick;
        end
    endtask

    // Ack for one cycle; returns set pulses in the ack cycle and int_req/set_i afterwards
    task automatic acknowledge(output logic si, output logic sf, output logic req_after, output logic si_after);
        bus.int_ack = 1'b1; #1;
        si = bus.set_i; sf = bus.set_f;
        tick;
        bus.int_ack = 1'b0; #1;
        req_after = bus.int_req; si_after = bus.set_i;
    endtask

    task automatic finish_svc;
        bus.int_done = 1'b1; tick; bus.int_done = 1'b0;
    endtask

    task automatic test_reset;
        logic si, sf, ra, sa;
        idle_pins;
        rst = 1'b1;
        repeat (2) tick;
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL rst_int_req: got %b want 1", bus.int_req); end
        checks++; if (bus.vec_addr !== V_RST) begin errors++; $display("FAIL rst_vec: got %h want %h", bus.vec_addr, V_RST); end
        checks++; if (bus.int_firq !== 1'b0) begin errors++; $display("FAIL rst_firq: got %b want 0", bus.int_firq); end
        bus.int_ack = 1'b1; #1;
        checks++; if ({bus.set_i, bus.set_f} !== 2'b00) begin errors++; $display("FAIL rst_sets_in_reset: got %b want 00", {bus.set_i, bus.set_f}); end
        bus.int_ack = 1'b0;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({bus.int_req, bus.set_i, bus.set_f} !== 3'b100) begin errors++; $display("FAIL rst_wait_ack%0d: got req/si/sf=%b want 100", i, {bus.int_req, bus.set_i, bus.set_f}); end
        end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b11) begin errors++; $display("FAIL rst_ack_sets: got %b want 11", {si, sf}); end
        checks++; if ({ra, sa} !== 2'b00) begin errors++; $display("FAIL rst_after_ack: got req/si=%b want 00", {ra, sa}); end
        finish_svc;
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rst_idle_req: got %b want 0", bus.int_req); end
    endtask

    task automatic test_irq_latency;
        int n;
        logic si, sf, ra, sa;
        bus.irq_n = 1'b0; bus.cc_i = 1'b0; bus.insn_end = 1'b1;
        n = 0;
        while (!bus.int_req && n < 6) begin tick; n++; end
        bus.insn_end = 1'b0;
        checks++; if (n > 4) begin errors++; $display("FAIL irq_latency: got %0d cycles want <=4", n); end
        checks++; if (bus.vec_addr !== V_IRQ) begin errors++; $display("FAIL irq_vec: got %h want %h", bus.vec_addr, V_IRQ); end
        checks++; if (bus.int_firq !== 1'b0) begin errors++; $display("FAIL irq_firq: got %b want 0", bus.int_firq); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b10) begin errors++; $display("FAIL irq_ack_sets: got %b want 10", {si, sf}); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL irq_req_fall: got %b want 0", ra); end
        finish_svc;
        idle_pins; settle;
    endtask

    task automatic test_priority;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        bus.irq_n = 1'b0; bus.firq_n = 1'b0; settle;
        request(got, vec, firq);
        checks++; if ({got, vec, firq} !== {1'b1, V_FIRQ, 1'b1}) begin errors++; $display("FAIL prio_firq: got req=%b vec=%h firq=%b want 1 %h 1", got, vec, firq, V_FIRQ); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b11) begin errors++; $display("FAIL prio_firq_sets: got %b want 11", {si, sf}); end
        finish_svc;
        checks++; if (bus.int_firq !== 1'b0) begin errors++; $display("FAIL prio_firq_idle: got %b want 0", bus.int_firq); end
        bus.cc_f = 1'b1; settle;
        request(got, vec, firq);
        checks++; if ({got, vec, firq} !== {1'b1, V_IRQ, 1'b0}) begin errors++; $display("FAIL prio_masked_firq: got req=%b vec=%h firq=%b want 1 %h 0", got, vec, firq, V_IRQ); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b10) begin errors++; $display("FAIL prio_irq_sets: got %b want 10", {si, sf}); end
        finish_svc;
        idle_pins; settle;
    endtask

    task automatic test_irq_drop;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        bus.irq_n = 1'b0; settle;
        request(got, vec, firq);
        checks++; if (vec !== V_IRQ) begin errors++; $display("FAIL drop_vec: got %h want %h", vec, V_IRQ); end
        bus.irq_n = 1'b1; bus.cc_i = 1'b1; bus.firq_n = 1'b0;
        repeat (4) tick;
        checks++; if ({bus.int_req, bus.vec_addr, bus.int_firq} !== {1'b1, V_IRQ, 1'b0}) begin errors++; $display("FAIL drop_hold: got req=%b vec=%h firq=%b want 1 %h 0", bus.int_req, bus.vec_addr, bus.int_firq, V_IRQ); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf, ra} !== 3'b100) begin errors++; $display("FAIL drop_ack: got si/sf/req=%b want 100", {si, sf, ra}); end
        finish_svc;
        idle_pins; settle;
        request(got, vec, firq);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL drop_no_repeat: got req=%b want 0", got); end
    endtask

    task automatic test_nmi_in_svc;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        pulse_s_wr;
        bus.irq_n = 1'b0; settle;
        request(got, vec, firq);
        acknowledge(si, sf, ra, sa);
        bus.irq_n = 1'b1;
        nmi_edge;
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL nmi_wait_done: got req=%b want 0", bus.int_req); end
        finish_svc;
        request(got, vec, firq);
        checks++; if ({got, vec} !== {1'b1, V_NMI}) begin errors++; $display("FAIL nmi_vec: got req=%b vec=%h want 1 %h", got, vec, V_NMI); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b11) begin errors++; $display("FAIL nmi_sets: got %b want 11", {si, sf}); end
        finish_svc;
        request(got, vec, firq);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL nmi_once: got req=%b want 0", got); end
        if (got) begin acknowledge(si, sf, ra, sa); finish_svc; end
    endtask

    task automatic test_nmi_collision;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        nmi_edge;
        request(got, vec, firq);
        checks++; if (vec !== V_NMI) begin errors++; $display("FAIL coll_first_vec: got %h want %h", vec, V_NMI); end
        // New edge reaches the detector on the same cycle the NMI is acknowledged
        bus.nmi_n = 1'b0; tick; tick;
        acknowledge(si, sf, ra, sa);
        bus.nmi_n = 1'b1; settle;
        finish_svc;
        request(got, vec, firq);
        checks++; if ({got, vec} !== {1'b1, V_NMI}) begin errors++; $display("FAIL coll_pend_kept: got req=%b vec=%h want 1 %h", got, vec, V_NMI); end
        acknowledge(si, sf, ra, sa);
        finish_svc;
        request(got, vec, firq);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL coll_cleared: got req=%b want 0", got); end
        if (got) begin acknowledge(si, sf, ra, sa); finish_svc; end
    endtask

    task automatic test_cen_hold;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        bus.irq_n = 1'b0; settle;
        request(got, vec, firq);
        cen = 1'b0;
        bus.irq_n = 1'b1; bus.firq_n = 1'b0; bus.int_ack = 1'b1; #1;
        checks++; if ({bus.set_i, bus.set_f} !== 2'b00) begin errors++; $display("FAIL cen_sets: got %b want 00", {bus.set_i, bus.set_f}); end
        repeat (3) tick;
        checks++; if ({bus.int_req, bus.vec_addr} !== {1'b1, V_IRQ}) begin errors++; $display("FAIL cen_hold: got req=%b vec=%h want 1 %h", bus.int_req, bus.vec_addr, V_IRQ); end
        bus.int_ack = 1'b0; cen = 1'b1;
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf, ra} !== 3'b100) begin errors++; $display("FAIL cen_ack: got si/sf/req=%b want 100", {si, sf, ra}); end
        finish_svc;
        idle_pins; settle;
    endtask

    task automatic test_reset_mid;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        bus.irq_n = 1'b0; settle;
        request(got, vec, firq);
        #2 rst = 1'b1; #1;
        checks++; if ({bus.int_req, bus.vec_addr} !== {1'b1, V_RST}) begin errors++; $display("FAIL rstmid_async: got req=%b vec=%h want 1 %h", bus.int_req, bus.vec_addr, V_RST); end
        tick;
        rst = 1'b0; bus.irq_n = 1'b1;
        tick;
        checks++; if (bus.vec_addr !== V_RST) begin errors++; $display("FAIL rstmid_vec: got %h want %h", bus.vec_addr, V_RST); end
        acknowledge(si, sf, ra, sa);
        checks++; if ({si, sf} !== 2'b11) begin errors++; $display("FAIL rstmid_sets: got %b want 11", {si, sf}); end
        finish_svc; settle;
        request(got, vec, firq);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL rstmid_abandon: got req=%b want 0", got); end
        if (got) begin acknowledge(si, sf, ra, sa); finish_svc; end
    endtask

    task automatic test_nmi_arm;
        bit got;
        logic [15:0] vec;
        logic firq, si, sf, ra, sa;
        bit exp_before;
`ifdef JTKCPU_NMI_ARM_EN
        exp_before = 1'b0;
`else
        exp_before = 1'b1;
`endif
        rst = 1'b1; tick; rst = 1'b0; tick;
        acknowledge(si, sf, ra, sa); finish_svc;
        nmi_edge;
        request(got, vec, firq);
        checks++; if (got !== exp_before) begin errors++; $display("FAIL arm_before_swr: got req=%b want %b", got, exp_before); end
        if (got) begin acknowledge(si, sf, ra, sa); finish_svc; end
        pulse_s_wr;
        nmi_edge;
        request(got, vec, firq);
        checks++; if ({got, vec} !== {1'b1, V_NMI}) begin errors++; $display("FAIL arm_after_swr: got req=%b vec=%h want 1 %h", got, vec, V_NMI); end
        acknowledge(si, sf, ra, sa); finish_svc;
    endtask

    task automatic test_random;
        bit got;
        logic [15:0] vec, exp;
        logic firq, si, sf, ra, sa;
        m_nmi = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin nmi_edge; m_nmi = 1'b1; end
            bus.irq_n  = 1'($urandom_range(0, 1));
            bus.firq_n = 1'($urandom_range(0, 1));
            bus.cc_i   = 1'($urandom_range(0, 1));
            bus.cc_f   = 1'($urandom_range(0, 1));
            settle;
            exp = model_vec(m_nmi, bus.firq_n, bus.irq_n, bus.cc_f, bus.cc_i);
            request(got, vec, firq);
            checks++; if (got !== (exp != V_NONE)) begin errors++; $display("FAIL rnd%0d_req: got %b want %b", it, got, exp != V_NONE); end
            if (got && exp != V_NONE) begin
                checks++; if ({vec, firq} !== {exp, exp == V_FIRQ}) begin errors++; $display("FAIL rnd%0d_vec: got %h/%b want %h/%b", it, vec, firq, exp, exp == V_FIRQ); end
                bus.irq_n  = 1'($urandom_range(0, 1));
                bus.firq_n = 1'($urandom_range(0, 1));
                bus.cc_i   = 1'($urandom_range(0, 1));
                bus.cc_f   = 1'($urandom_range(0, 1));
                repeat (2) tick;
                checks++; if ({bus.int_req, bus.vec_addr} !== {1'b1, exp}) begin errors++; $display("FAIL rnd%0d_hold: got %b/%h want 1/%h", it, bus.int_req, bus.vec_addr, exp); end
                acknowledge(si, sf, ra, sa);
                checks++; if ({si, sf, ra} !== {1'b1, exp != V_IRQ, 1'b0}) begin errors++; $display("FAIL rnd%0d_ack: got si/sf/req=%b want %b", it, {si, sf, ra}, {1'b1, exp != V_IRQ, 1'b0}); end
                if (exp == V_NMI) m_nmi = 1'b0;
                finish_svc;
            end else if (got) begin
                acknowledge(si, sf, ra, sa); finish_svc;
            end
        end
        idle_pins; settle;
    endtask

    initial begin
        idle_pins;
        test_reset;
        test_irq_latency;
        test_priority;
        test_irq_drop;
        test_nmi_in_svc;
        test_nmi_collision;
        test_cen_hold;
        test_reset_mid;
        test_nmi_arm;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtkcpu_irq.md
JTKCPU_IRQ -- requirements
Module: jtkcpu_irq

Interface
REQ-001 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have port clk  in  1  single clock for all state.
REQ-003 SHALL have port cen  in  1  clock enable; all state advances only when cen=1.
REQ-004 SHALL have ports nmi_n, firq_n, irq_n  in  1 each  raw CPU interrupt pins, active-low, asynchronous to clk.
REQ-005 SHALL have ports cc_i, cc_f  in  1 each  current CC I and F mask bits.
REQ-006 SHALL have port insn_end  in  1  pulse from the controller at each instruction boundary.
REQ-007 SHALL have ports int_ack, int_done  in  1 each  controller accepted the request / vector loaded into PC.
REQ-008 SHALL have port s_wr  in  1  pulse when the S register is written.
REQ-009 SHALL have port int_req  out  1  service request to the controller.
REQ-010 SHALL have port vec_addr  out  16  vector address for the current request.
REQ-011 SHALL have port int_firq  out  1  short stack frame (PC and CC only; E cleared).
REQ-012 SHALL have ports set_i, set_f  out  1 each  one-cycle pulses to set CC mask bits.

Function
REQ-013 SHALL pass each pin through a two-stage synchroniser clocked on cen; all internal decisions use the synchronised values.
REQ-014 SHALL latch nmi_pend on a synchronised falling edge of nmi_n; FIRQ and IRQ SHALL be level-sensitive and are not latched.
REQ-015 SHALL treat FIRQ as pending when firq low and cc_f=0, and IRQ as pending when irq low and cc_i=0.
REQ-016 SHALL prioritise reset > NMI > FIRQ > IRQ, with vectors FFFE, FFFC, FFF6 and FFF8 respectively.
REQ-017 SHALL implement FSM states RST, IDLE, REQ and SVC.
REQ-018 RST SHALL drive int_req=1 and vec_addr=FFFE; on int_ack it SHALL pulse set_i and set_f and go to SVC.
REQ-019 IDLE SHALL evaluate pending sources only on cycles with insn_end=1 and cen=1; if any source is pending it SHALL freeze the winner and go to REQ on the next cycle.
REQ-020 REQ SHALL hold int_req=1 and hold vec_addr and int_firq stable until int_ack, regardless of pin or mask changes.
REQ-021 On int_ack: NMI SHALL pulse set_i and set_f and clear nmi_pend; FIRQ SHALL pulse set_i and set_f; IRQ SHALL pulse set_i only. The FSM SHALL then go to SVC and int_req SHALL fall in the same cycle.
REQ-022 SVC SHALL wait for int_done and then return to IDLE; no new request is raised before int_done.
REQ-023 int_firq SHALL be 1 only while FIRQ is the frozen winner.
REQ-024 If a new NMI edge and an NMI-clearing int_ack occur in the same cycle, set SHALL win and nmi_pend SHALL remain 1.
REQ-025 If FIRQ or IRQ is deasserted while in REQ, the request SHALL still complete with the frozen vector.
REQ-026 With cen=0, all outputs and state SHALL hold, and set_i and set_f SHALL be 0.

Reset
REQ-027 rst=1 SHALL asynchronously force state=RST, int_req=1, vec_addr=FFFE, int_firq=0, set_i=0, set_f=0, nmi_pend=0 and synchronisers=1 (inactive).
REQ-028 Reset asserted during REQ or SVC SHALL abandon the request; after release only the reset vector is issued.

Configuration
REQ-029 The macro JTKCPU_NMI_ARM_EN SHALL control NMI arming.
REQ-030 With JTKCPU_NMI_ARM_EN defined, NMI edges SHALL be ignored until the first s_wr pulse after reset; the armed flag SHALL be cleared by reset.
REQ-031 Without JTKCPU_NMI_ARM_EN, NMI SHALL be armed permanently and s_wr SHALL be ignored.

Verification
REQ-032 Reset release with ack 3 cycles later -> vec_addr=FFFE, int_req=1 until ack, set_i and set_f pulse once.
REQ-033 irq_n=0 and cc_i=0, then insn_end -> int_req within 4 cen cycles (2 sync + 1 evaluate + 1 FSM) with vec_addr=FFF8; on ack set_i pulses and set_f=0.
REQ-034 irq_n=0 and firq_n=0 with both masks clear -> FFF6 and int_firq=1; with cc_f=1 instead -> FFF8.
REQ-035 An NMI falling edge during SVC of an IRQ -> after int_done, the next insn_end yields FFFC; a single NMI edge is serviced exactly once.
REQ-036 With JTKCPU_NMI_ARM_EN defined, an NMI edge before s_wr -> no request; an edge after s_wr -> FFFC.
REQ-037 IRQ request in REQ, then irq_n=1 before ack -> FFF8 held, completes normally.
